nmi_rr_arbiter: RTL and testbench
=================================

// Module: nmi_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one NMI slave (e.g. nmi_memory) between N_MASTERS NMI masters.
//  Sits between CPU instruction/data ports or DMA masters and a single-ported NMI memory/peripheral.
//  Grants are decided combinationally in IDLE, preserving the slave's zero-wait access.
//  A grant stays locked to one master while the slave stalls.
// PARAMETERS
//  N_MASTERS      2                      number of upstream masters, >=2
//  ADDR_WIDTH     32                     NMI address width
//  DATA_WIDTH     32                     NMI data width
//  WSTRB_WIDTH    (DATA_WIDTH-1)/8+1     byte strobes per word (derived)
//  ID_WIDTH       $clog2(N_MASTERS)      grant index width (derived)
//  TIMEOUT_CYCLES 256                    stall limit; used only with NMI_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1                      single clock; all state on posedge clk
//  rstn         in   1                      asynchronous, active-low reset
//  s_nmi_valid  in   N_MASTERS              per-master request
//  s_nmi_instr  in   N_MASTERS              per-master instruction-fetch flag
//  s_nmi_ready  out  N_MASTERS              per-master completion; one-hot or zero
//  s_nmi_addr   in   N_MASTERS*ADDR_WIDTH   packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  s_nmi_wdata  in   N_MASTERS*DATA_WIDTH   packed write data
//  s_nmi_wstrb  in   N_MASTERS*WSTRB_WIDTH  packed strobes; all-zero = read
//  s_nmi_rdata  out  N_MASTERS*DATA_WIDTH   slave rdata copied to every lane
//  m_nmi_valid  out  1                      to shared slave
//  m_nmi_instr  out  1                      muxed from granted master
//  m_nmi_ready  in   1                      from shared slave
//  m_nmi_addr   out  ADDR_WIDTH             muxed from granted master
//  m_nmi_wdata  out  DATA_WIDTH             muxed from granted master
//  m_nmi_wstrb  out  WSTRB_WIDTH            muxed from granted master
//  m_nmi_rdata  in   DATA_WIDTH             from shared slave
//  grant_id     out  ID_WIDTH               index of currently forwarded master
//  timeout_err  out  1                      one-cycle pulse on forced abort; only with NMI_ARB_TIMEOUT_EN
// BEHAVIOUR
//  - States: IDLE, LOCKED. Registers: state, rr_ptr[ID_WIDTH], lock_id[ID_WIDTH].
//  - Reset: state=IDLE, rr_ptr=0, lock_id=0. While rstn=0: m_nmi_valid=0, s_nmi_ready=0, grant_id=0.
//  - IDLE winner: first i with s_nmi_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_MASTERS.
//  - IDLE, no valid: m_nmi_valid=0, grant_id=rr_ptr, m_* payload muxed from master rr_ptr.
//  - IDLE, winner w: forward w same cycle (m_nmi_valid=1), grant_id=w.
//    - m_nmi_ready=1: s_nmi_ready[w]=1; rr_ptr<=(w+1) mod N; stay IDLE. Zero added latency.
//    - m_nmi_ready=0: lock_id<=w; state<=LOCKED.
//  - LOCKED: forward only lock_id; other valids ignored, their ready=0.
//    - m_nmi_ready=1: s_nmi_ready[lock_id]=1; rr_ptr<=(lock_id+1) mod N; state<=IDLE.
//    - Next arbitration happens the cycle after completion.
//  - Masters hold valid/addr/wdata/wstrb stable until ready; deassertion while LOCKED is illegal (unchecked).
//  - Ready is combinational from m_nmi_ready and only to the forwarded master.
//  - rdata is wired through unregistered.
//  - Back-to-back requests from the same master: the grant rotates to another requester if one is valid.
//  - A lone requester is re-granted every cycle (no bubble).
//  - rr_ptr wraps N_MASTERS-1 -> 0. Non-power-of-two N uses explicit mod compare, no truncation.
//  - Async reset mid-transaction drops the lock immediately; the master sees no ready.
// CONFIGURATION
//  NMI_ARB_TIMEOUT_EN defined:
//    - stall_cnt[$clog2(TIMEOUT_CYCLES+1)] counts LOCKED cycles and is cleared on IDLE entry.
//    - When stall_cnt==TIMEOUT_CYCLES-1 and m_nmi_ready=0: s_nmi_ready[lock_id]=1, s_nmi_rdata lanes=0,
//      timeout_err=1 for that cycle, state<=IDLE, rr_ptr advances.
//    - m_nmi_valid drops next cycle; a slave write is not guaranteed to have landed.
//  NMI_ARB_TIMEOUT_EN undefined: no counter, no timeout_err port, a stalled slave locks forever.
// STRUCTURE
//  - nmi_arb_pkg: state enum (IDLE=1'b0, LOCKED=1'b1), function rr_next(ptr,n).
//  - Sub-module nmi_rr_picker: combinational (req[N], ptr) -> (any, idx). Unit-testable alone.
//  - Top: state/pointer regs, payload muxes, ready demux, optional timeout counter.
// TESTING
//  1 Reset: rstn=0 while s_nmi_valid=2'b11 -> m_nmi_valid=0, s_nmi_ready=0; after release rr_ptr=0 so master0 wins.
//  2 Contention, N=2, always-ready slave, both valid 4 cycles -> grant_id 0,1,0,1; s_nmi_ready 01,10,01,10.
//  3 Stall: master1 writes addr 0x10 with slave ready low 3 cycles; master0 valid meanwhile ->
//    m_nmi_addr=0x10 held, grant_id=1 for 4 cycles; master0 granted the cycle after completion.
//  4 Data path: master0 writes 0xA5A5A5A5 wstrb 4'hF to 0x8, then master1 reads 0x8 via nmi_memory ->
//    s_nmi_rdata lane1=0xA5A5A5A5.
//  5 Wrap, N=3, only master2 then only master0 valid -> rr_ptr 0->0->1 (wrap 2->0); no idle bubble.
//  6 NMI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave ready stuck 0 ->
//    timeout_err pulses on 4th LOCKED cycle, s_nmi_ready[w]=1, rdata=0, state IDLE.

Source files
------------

// File: rtl/nmi_arb_pkg.sv
// Shared types and helpers for the NMI round-robin arbiter.
// Arbiter state encoding and pointer advance.
package nmi_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/nmi_rr_picker.sv
// Combinational round-robin picker: nearest requester at or after ptr.
// Distance is computed modulo N so non-power-of-two N never aliases.
module nmi_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    int best;
    int d;
    any  = 1'b0;
    idx  = '0;
    best = N;
    d    = 0;
    for (int i = 0; i < N; i++) begin
      d = (i >= int'(ptr)) ? i - int'(ptr)
                           : i + N - int'(ptr);
      if (req[i] && d < best) begin
        best = d;
        any  = 1'b1;
        idx  = IW'(i);
      end
    end
  end

endmodule

// File: rtl/nmi_rr_arbiter.sv
// Round-robin arbiter sharing one NMI slave among N_MASTERS masters.
// Optional stall timeout: define NMI_ARB_TIMEOUT_EN.
module nmi_rr_arbiter
  import nmi_arb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WSTRB_WIDTH    = (DATA_WIDTH-1)/8+1,
  parameter int ID_WIDTH       = $clog2(N_MASTERS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [N_MASTERS-1:0]             s_nmi_valid,
  input  logic [N_MASTERS-1:0]             s_nmi_instr,
  output logic [N_MASTERS-1:0]             s_nmi_ready,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  s_nmi_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  s_nmi_wdata,
  input  logic [N_MASTERS*WSTRB_WIDTH-1:0] s_nmi_wstrb,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  s_nmi_rdata,
  output logic                             m_nmi_valid,
  output logic                             m_nmi_instr,
  input  logic                             m_nmi_ready,
  output logic [ADDR_WIDTH-1:0]            m_nmi_addr,
  output logic [DATA_WIDTH-1:0]            m_nmi_wdata,
  output logic [WSTRB_WIDTH-1:0]           m_nmi_wstrb,
  input  logic [DATA_WIDTH-1:0]            m_nmi_rdata,
  output logic [ID_WIDTH-1:0]              grant_id
`ifdef NMI_ARB_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  arb_state_e          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] lock_id;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [ID_WIDTH-1:0] sel;
  logic                pick_any;
  logic                fwd;
  logic                done;
  logic                tmo;

  nmi_rr_picker #(
    .N  (N_MASTERS),
    .IW (ID_WIDTH)
  ) u_pick (
    .req (s_nmi_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel = rr_ptr;
    fwd = 1'b0;
    unique case (state)
      IDLE: begin
        sel = pick_any ? pick_idx : rr_ptr;
        fwd = pick_any;
      end
      LOCKED: begin
        sel = lock_id;
        fwd = 1'b1;
      end
      default: begin
        sel = rr_ptr;
        fwd = 1'b0;
      end
    endcase
  end

`ifdef NMI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);

  logic [CW-1:0] stall_cnt;

  assign tmo = (state == LOCKED) && !m_nmi_ready &&
               (stall_cnt == CW'(TIMEOUT_CYCLES-1));
  assign timeout_err = rstn & tmo;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (state == LOCKED && !done) begin
      stall_cnt <= stall_cnt + CW'(1);
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Outputs are forced quiet while reset is asserted.
  assign done        = rstn & fwd & (m_nmi_ready | tmo);
  assign m_nmi_valid = rstn & fwd;
  assign grant_id    = rstn ? sel : '0;

  always_comb begin
    m_nmi_instr = 1'b0;
    m_nmi_addr  = '0;
    m_nmi_wdata = '0;
    m_nmi_wstrb = '0;
    s_nmi_ready = '0;
    s_nmi_rdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (sel == ID_WIDTH'(i)) begin
        m_nmi_instr = s_nmi_instr[i];
        m_nmi_addr  = s_nmi_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_nmi_wdata = s_nmi_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_nmi_wstrb = s_nmi_wstrb[i*WSTRB_WIDTH +: WSTRB_WIDTH];
        s_nmi_ready[i] = done;
      end
      s_nmi_rdata[i*DATA_WIDTH +: DATA_WIDTH] =
        tmo ? '0 : m_nmi_rdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (fwd) begin
      if (done) begin
        rr_ptr <= ID_WIDTH'(rr_next(int'(sel), N_MASTERS));
        state  <= IDLE;
      end else if (state == IDLE) begin
        lock_id <= sel;
        state   <= LOCKED;
      end
    end
  end

endmodule

// File: tb/tb_nmi_rr_arbiter.sv
// Testbench for nmi_rr_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin reference model.
module tb_nmi_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: two masters with a small memory slave
  logic [1:0]      va, ia, ra;
  logic [2*AW-1:0] addr_a;
  logic [2*DW-1:0] wd_a, rd_a;
  logic [2*SW-1:0] ws_a;
  logic            mv_a, mi_a, mr_a;
  logic [AW-1:0]   ma_a;
  logic [DW-1:0]   mwd_a, mrd_a;
  logic [SW-1:0]   mws_a;
  logic [0:0]      gid_a;

  // Instance B: three masters, always-ready slave
  logic [2:0]      vb, ib, rb;
  logic [3*AW-1:0] addr_b;
  logic [3*DW-1:0] wd_b, rd_b;
  logic [3*SW-1:0] ws_b;
  logic            mv_b, mi_b, mr_b;
  logic [AW-1:0]   ma_b;
  logic [DW-1:0]   mwd_b, mrd_b;
  logic [SW-1:0]   mws_b;
  logic [1:0]      gid_b;

`ifdef NMI_ARB_TIMEOUT_EN
  logic te_a, te_b, te_c;
  logic [1:0]      vc, ic, rc;
  logic [2*AW-1:0] addr_c;
  logic [2*DW-1:0] wd_c, rd_c;
  logic [2*SW-1:0] ws_c;
  logic            mv_c, mi_c, mr_c;
  logic [AW-1:0]   ma_c;
  logic [DW-1:0]   mwd_c, mrd_c;
  logic [SW-1:0]   mws_c;
  logic [0:0]      gid_c;
`endif

  nmi_rr_arbiter #(.N_MASTERS(2)) dut_a (
    .clk(clk), .rstn(rstn),
    .s_nmi_valid(va), .s_nmi_instr(ia), .s_nmi_ready(ra),
    .s_nmi_addr(addr_a), .s_nmi_wdata(wd_a),
    .s_nmi_wstrb(ws_a), .s_nmi_rdata(rd_a),
    .m_nmi_valid(mv_a), .m_nmi_instr(mi_a), .m_nmi_ready(mr_a),
    .m_nmi_addr(ma_a), .m_nmi_wdata(mwd_a),
    .m_nmi_wstrb(mws_a), .m_nmi_rdata(mrd_a),
    .grant_id(gid_a)
`ifdef NMI_ARB_TIMEOUT_EN
    , .timeout_err(te_a)
`endif
  );

  nmi_rr_arbiter #(.N_MASTERS(3)) dut_b (
    .clk(clk), .rstn(rstn),
    .s_nmi_valid(vb), .s_nmi_instr(ib), .s_nmi_ready(rb),
    .s_nmi_addr(addr_b), .s_nmi_wdata(wd_b),
    .s_nmi_wstrb(ws_b), .s_nmi_rdata(rd_b),
    .m_nmi_valid(mv_b), .m_nmi_instr(mi_b), .m_nmi_ready(mr_b),
    .m_nmi_addr(ma_b), .m_nmi_wdata(mwd_b),
    .m_nmi_wstrb(mws_b), .m_nmi_rdata(mrd_b),
    .grant_id(gid_b)
`ifdef NMI_ARB_TIMEOUT_EN
    , .timeout_err(te_b)
`endif
  );

`ifdef NMI_ARB_TIMEOUT_EN
  nmi_rr_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(4)) dut_c (
    .clk(clk), .rstn(rstn),
    .s_nmi_valid(vc), .s_nmi_instr(ic), .s_nmi_ready(rc),
    .s_nmi_addr(addr_c), .s_nmi_wdata(wd_c),
    .s_nmi_wstrb(ws_c), .s_nmi_rdata(rd_c),
    .m_nmi_valid(mv_c), .m_nmi_instr(mi_c), .m_nmi_ready(mr_c),
    .m_nmi_addr(ma_c), .m_nmi_wdata(mwd_c),
    .m_nmi_wstrb(mws_c), .m_nmi_rdata(mrd_c),
    .grant_id(gid_c), .timeout_err(te_c)
  );
`endif

  // Memory slave behind instance A, and the bench's own reference copy
  logic [31:0] smem    [0:63];
  logic [31:0] ref_mem [0:63];

  assign mrd_a = smem[ma_a[7:2]];
  assign mrd_b = 32'h0;

  always @(posedge clk) begin
    if (rstn && mv_a && mr_a)
      for (int b = 0; b < 4; b++)
        if (mws_a[b])
          smem[ma_a[7:2]][b*8 +: 8] <= mwd_a[b*8 +: 8];
  end

  function automatic void ref_write(input logic [5:0] idx,
                                    input logic [31:0] d,
                                    input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic do_reset;
    rstn = 1'b0;
    va = '0; ia = '0; addr_a = '0; wd_a = '0; ws_a = '0; mr_a = 1'b0;
    vb = '0; ib = '0; addr_b = '0; wd_b = '0; ws_b = '0; mr_b = 1'b0;
`ifdef NMI_ARB_TIMEOUT_EN
    vc = '0; ic = '0; addr_c = '0; wd_c = '0; ws_c = '0; mr_c = 1'b0;
    mrd_c = 32'hDEADBEEF;
`endif
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    va = 2'b11;
    mr_a = 1'b1;
    #2;
    total++;
    if (mv_a !== 1'b0) begin
      bad++; $display("FAIL rst_mvalid got=%b want=0", mv_a);
    end
    total++;
    if (ra !== 2'b00) begin
      bad++; $display("FAIL rst_sready got=%b want=00", ra);
    end
    total++;
    if (gid_a !== 1'b0) begin
      bad++; $display("FAIL rst_gid got=%0d want=0", gid_a);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    #3;
    total++;
    if (ra !== 2'b01 || gid_a !== 1'b0) begin
      bad++; $display("FAIL rst_first got ready=%b gid=%0d want 01/0",
                      ra, gid_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    logic [1:0] er;
    do_reset();
    va = 2'b11;
    mr_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      er = (k % 2 == 0) ? 2'b01 : 2'b10;
      #3;
      total++;
      if (gid_a !== 1'(k % 2) || ra !== er) begin
        bad++;
        $display("FAIL contention[%0d] got gid=%0d ready=%b want %0d/%b",
                 k, gid_a, ra, k % 2, er);
      end
      @(posedge clk); #1;
    end
    va = 2'b00;
  endtask

  task automatic test_stall;
    do_reset();
    va = 2'b01; mr_a = 1'b1;
    #3;
    total++;
    if (ra !== 2'b01) begin
      bad++; $display("FAIL stall_pre got=%b want=01", ra);
    end
    @(posedge clk); #1;
    va = 2'b11;
    addr_a = {32'h10, 32'h40};
    wd_a = {32'hCAFE0010, 32'h0};
    ws_a = {4'hF, 4'h0};
    for (int k = 0; k < 4; k++) begin
      mr_a = (k == 3);
      #3;
      total++;
      if (gid_a !== 1'b1 || ma_a !== 32'h10 ||
          ra !== ((k == 3) ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL stall[%0d] got gid=%0d addr=%h ready=%b",
                 k, gid_a, ma_a, ra);
      end
      @(posedge clk); #1;
    end
    va = 2'b01;
    #3;
    total++;
    if (gid_a !== 1'b0 || ra !== 2'b01) begin
      bad++; $display("FAIL stall_after got gid=%0d ready=%b want 0/01",
                      gid_a, ra);
    end
    @(posedge clk); #1;
    // Lock master1, then pull reset mid-cycle
    va = 2'b11; mr_a = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    total++;
    if (mv_a !== 1'b0 || ra !== 2'b00 || gid_a !== 1'b0) begin
      bad++; $display("FAIL midrst got valid=%b ready=%b gid=%0d",
                      mv_a, ra, gid_a);
    end
    mr_a = 1'b1;
    #1;
    total++;
    if (ra !== 2'b00) begin
      bad++; $display("FAIL midrst_ready got=%b want=00", ra);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    #3;
    total++;
    if (gid_a !== 1'b0 || ra !== 2'b01) begin
      bad++; $display("FAIL midrst_release got gid=%0d ready=%b",
                      gid_a, ra);
    end
    @(posedge clk); #1;
    va = 2'b00;
  endtask

  task automatic test_datapath;
    do_reset();
    va = 2'b01; mr_a = 1'b1;
    addr_a = {32'h0, 32'h8};
    wd_a = {32'h0, 32'hA5A5A5A5};
    ws_a = {4'h0, 4'hF};
    #3;
    total++;
    if (ra !== 2'b01 || mwd_a !== 32'hA5A5A5A5 || mws_a !== 4'hF) begin
      bad++; $display("FAIL dp_write got ready=%b wdata=%h wstrb=%h",
                      ra, mwd_a, mws_a);
    end
    @(posedge clk); #1;
    va = 2'b10;
    addr_a = {32'h8, 32'h8};
    ws_a = 8'h00;
    #3;
    total++;
    if (ra !== 2'b10 || rd_a[63:32] !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL dp_read got ready=%b rdata=%h want 10/a5a5a5a5",
                      ra, rd_a[63:32]);
    end
    @(posedge clk); #1;
    va = 2'b00;
  endtask

  task automatic test_wrap;
    do_reset();
    mr_b = 1'b1;
    vb = 3'b100;
    #3;
    total++;
    if (gid_b !== 2'd2 || rb !== 3'b100) begin
      bad++; $display("FAIL wrap_m2 got gid=%0d ready=%b", gid_b, rb);
    end
    @(posedge clk); #1;
    vb = 3'b001;
    #3;
    total++;
    if (gid_b !== 2'd0 || rb !== 3'b001) begin
      bad++; $display("FAIL wrap_m0 got gid=%0d ready=%b", gid_b, rb);
    end
    @(posedge clk); #1;
    #3;
    total++;
    if (gid_b !== 2'd0 || rb !== 3'b001) begin
      bad++; $display("FAIL wrap_lone got gid=%0d ready=%b", gid_b, rb);
    end
    @(posedge clk); #1;
    vb = 3'b000;
    #3;
    total++;
    if (gid_b !== 2'd1 || mv_b !== 1'b0) begin
      bad++; $display("FAIL wrap_idle got gid=%0d valid=%b want 1/0",
                      gid_b, mv_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    bit          act [2];
    bit          ins [2];
    logic [31:0] ad  [2];
    logic [31:0] wdv [2];
    logic [3:0]  st  [2];
    int ptr, lock, w, stall;
    bit rdy;
    logic [1:0] er;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      smem[i] = '0; ref_mem[i] = '0;
    end
    ptr = 0; lock = -1; stall = 0;
    for (int m = 0; m < 2; m++) act[m] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int m = 0; m < 2; m++)
        if (!act[m] && $urandom_range(0, 9) < 6) begin
          act[m] = 1'b1;
          ins[m] = 1'($urandom);
          ad[m]  = {24'h0, 6'($urandom), 2'b00};
          wdv[m] = $urandom;
          st[m]  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        end
      rdy = (stall >= 3) || ($urandom_range(0, 9) < 7);
      if (lock >= 0) w = lock;
      else begin
        w = -1;
        for (int k = 0; k < 2; k++)
          if (w < 0 && act[(ptr + k) % 2]) w = (ptr + k) % 2;
      end
      va = {act[1], act[0]};
      ia = {ins[1], ins[0]};
      addr_a = {ad[1], ad[0]};
      wd_a = {wdv[1], wdv[0]};
      ws_a = {act[1] ? st[1] : 4'h0, act[0] ? st[0] : 4'h0};
      mr_a = rdy;
      er = (w >= 0 && rdy) ? 2'(1 << w) : 2'b00;
      #3;
      total++;
      if (mv_a !== (w >= 0) || ra !== er ||
          gid_a !== 1'((w >= 0) ? w : ptr)) begin
        bad++;
        $display("FAIL rnd_grant[%0d] got v=%b r=%b g=%0d want w=%0d r=%b p=%0d",
                 cyc, mv_a, ra, gid_a, w, er, ptr);
      end
      if (w >= 0) begin
        total++;
        if (ma_a !== ad[w] || mws_a !== st[w] || mi_a !== ins[w] ||
            (st[w] != 4'h0 && mwd_a !== wdv[w])) begin
          bad++;
          $display("FAIL rnd_payload[%0d] got a=%h s=%h d=%h want a=%h s=%h d=%h",
                   cyc, ma_a, mws_a, mwd_a, ad[w], st[w], wdv[w]);
        end
        if (rdy && st[w] == 4'h0) begin
          total++;
          if (rd_a[w*32 +: 32] !== ref_mem[ad[w][7:2]]) begin
            bad++;
            $display("FAIL rnd_rdata[%0d] got=%h want=%h",
                     cyc, rd_a[w*32 +: 32], ref_mem[ad[w][7:2]]);
          end
        end
      end
      @(posedge clk);
      if (w >= 0) begin
        if (rdy) begin
          ref_write(ad[w][7:2], wdv[w], st[w]);
          act[w] = 1'b0;
          ptr = (w + 1) % 2;
          lock = -1;
          stall = 0;
        end else begin
          lock = w;
          stall++;
        end
      end
      #1;
    end
    va = 2'b00;
  endtask

  task automatic test_rotation_b;
    int ptr, w;
    logic [2:0] v, er;
    do_reset();
    mr_b = 1'b1;
    ptr = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      v = 3'($urandom);
      w = -1;
      for (int k = 0; k < 3; k++)
        if (w < 0 && v[(ptr + k) % 3]) w = (ptr + k) % 3;
      vb = v;
      er = (w >= 0) ? 3'(1 << w) : 3'b000;
      #3;
      total++;
      if (rb !== er || gid_b !== 2'((w >= 0) ? w : ptr)) begin
        bad++;
        $display("FAIL rot3[%0d] got g=%0d r=%b want w=%0d r=%b p=%0d",
                 cyc, gid_b, rb, w, er, ptr);
      end
      @(posedge clk); #1;
      if (w >= 0) ptr = (w + 1) % 3;
    end
    vb = 3'b000;
  endtask

`ifdef NMI_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    vc = 2'b01;
    addr_c = {32'h0, 32'h20};
    mr_c = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #3;
      total++;
      if (te_c !== (k == 4) || rc !== ((k == 4) ? 2'b01 : 2'b00) ||
          mv_c !== 1'b1) begin
        bad++;
        $display("FAIL timeout[%0d] got err=%b ready=%b valid=%b",
                 k, te_c, rc, mv_c);
      end
      if (k == 4) begin
        total++;
        if (rd_c[31:0] !== 32'h0) begin
          bad++; $display("FAIL timeout_rdata got=%h want=0", rd_c[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    vc = 2'b00;
    #3;
    total++;
    if (mv_c !== 1'b0 || te_c !== 1'b0 || gid_c !== 1'b1) begin
      bad++; $display("FAIL timeout_after got valid=%b err=%b gid=%0d",
                      mv_c, te_c, gid_c);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    do_reset();
    test_reset();
    test_contention();
    test_stall();
    test_datapath();
    test_wrap();
    test_random();
    test_rotation_b();
`ifdef NMI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
